// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared types and constants for the bit-serial adder.
//   state_t       - FSM encoding (IDLE, RUN, DONE)
//   SA_DEF_WIDTH  - default operand width
//   sa_cnt_w()    - bit-counter width, never below 1
package serial_adder_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam int SA_DEF_WIDTH = 8;

    // Counter must count 0..w-1; a 1-bit operand still needs a 1-bit counter.
    function automatic int sa_cnt_w(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/serial_adder_if.sv
// serial_adder_if: operand/result handshake bundle of the serial adder.
//   in_valid/in_ready, a, b, c_in       - operand channel (producer -> adder)
//   out_valid/out_ready, sum, c_out     - result channel  (adder -> consumer)
//   ovf                                 - signed overflow, only when
//                                         SERIAL_ADDER_OVF_EN is defined
//   modport slave  : the adder side
//   modport master : the producer/consumer side
interface serial_adder_if
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = SA_DEF_WIDTH
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             c_out;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf;

    modport slave  (input  in_valid, a, b, c_in, out_ready,
                    output in_ready, out_valid, sum, c_out, ovf);
    modport master (output in_valid, a, b, c_in, out_ready,
                    input  in_ready, out_valid, sum, c_out, ovf);
`else
    modport slave  (input  in_valid, a, b, c_in, out_ready,
                    output in_ready, out_valid, sum, c_out);
    modport master (output in_valid, a, b, c_in, out_ready,
                    input  in_ready, out_valid, sum, c_out);
`endif

endinterface

// File: rtl/half_adder.sv
// half_adder: 1-bit half adder datapath cell.
//   i_a, i_b : addend bits
//   o_s      : sum bit   (i_a ^ i_b)
//   o_c      : carry bit (i_a & i_b)
module half_adder (
    input  logic i_a,
    input  logic i_b,
    output logic o_s,
    output logic o_c
);
    assign o_s = i_a ^ i_b;
    assign o_c = i_a & i_b;
endmodule

// File: rtl/serial_adder_fa_slice.sv
// fa_slice: combinational full-adder slice built from two half adders.
//   x, y : operand bits
//   ci   : carry in
//   s    : sum bit
//   co   : carry out (OR of the two half-adder carries; they are never both 1)
module fa_slice (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);
    logic w_s0;
    logic w_c0;
    logic w_c1;

    half_adder u_ha0 (.i_a(x),    .i_b(y),  .o_s(w_s0), .o_c(w_c0));
    half_adder u_ha1 (.i_a(w_s0), .i_b(ci), .o_s(s),    .o_c(w_c1));

    assign co = w_c0 | w_c1;
endmodule

// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit adder, one bit per clock, LSB first.
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : serial_adder_if.slave (operand and result handshakes)
//   busy : high while in RUN or DONE
// Optional macro SERIAL_ADDER_OVF_EN adds bus.ovf, the two's-complement
// overflow of the finished addition, valid with out_valid.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = SA_DEF_WIDTH
) (
    input  logic           clk,
    input  logic           rst,
    serial_adder_if.slave  bus,
    output logic           busy
);
    localparam int CW = sa_cnt_w(WIDTH);

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_s;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic             r_in_ready;
    logic             r_out_valid;
    logic             r_busy;
`ifdef SERIAL_ADDER_OVF_EN
    logic             r_ovf;
`endif

    logic             w_s;
    logic             w_co;
    logic             w_last;
    logic [WIDTH-1:0] w_s_nxt;

    fa_slice u_fa (.x(r_a[0]), .y(r_b[0]), .ci(r_carry), .s(w_s), .co(w_co));

    assign w_last = (r_cnt == CW'(WIDTH - 1));

    // Sum bits enter at the top and walk down, so after WIDTH shifts bit 0
    // of the result sits at r_s[0]. A 1-bit result has nothing to shift.
    generate
        if (WIDTH == 1) begin : g_s1
            assign w_s_nxt = w_s;
        end else begin : g_sn
            assign w_s_nxt = {w_s, r_s[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_s         <= '0;
            r_carry     <= 1'b0;
            r_cnt       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            r_ovf       <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        r_a        <= bus.a;
                        r_b        <= bus.b;
                        r_carry    <= bus.c_in;
                        r_cnt      <= '0;
                        r_state    <= RUN;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                    end
                end
                RUN: begin
                    r_a     <= r_a >> 1;
                    r_b     <= r_b >> 1;
                    r_s     <= w_s_nxt;
                    r_carry <= w_co;
                    r_cnt   <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_state     <= DONE;
                        r_out_valid <= 1'b1;
`ifdef SERIAL_ADDER_OVF_EN
                        // MSB slice: carry in is r_carry, carry out is w_co.
                        r_ovf       <= r_carry ^ w_co;
`endif
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        r_state     <= IDLE;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.sum       = r_s;
    assign bus.c_out     = r_carry;
    assign busy          = r_busy;
`ifdef SERIAL_ADDER_OVF_EN
    assign bus.ovf       = r_ovf;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: self-checking bench for serial_adder (WIDTH=8).
// Directed corner cases, backpressure, reset mid-operation, then 200 random
// operations scored against plain integer arithmetic.
module tb_serial_adder;
    import serial_adder_pkg::*;

    localparam int W = 8;

    logic clk = 1'b0;
    logic rst;
    logic busy;

    serial_adder_if #(.WIDTH(W)) bus ();

    serial_adder #(.WIDTH(W)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus.slave),
        .busy (busy)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: unsigned sum including carry, as a WIDTH+1 bit value.
    function automatic logic [63:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic ci);
        longint s;
        s = longint'(a) + longint'(b) + longint'(ci);
        return 64'(s);
    endfunction

    // Reference: signed result outside the W-bit two's-complement range.
    function automatic logic ref_ovf(input logic [W-1:0] a, input logic [W-1:0] b,
                                     input logic ci);
        int sa, sb, s;
        sa = $signed(a);
        sb = $signed(b);
        s  = sa + sb + int'(ci);
        return (s > (1 << (W-1)) - 1) || (s < -(1 << (W-1)));
    endfunction

    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic ci, input int hold);
        int n;
        logic [63:0] exp;
        exp = ref_add(a, b, ci);
        @(negedge clk);
        n = 0;
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_rdy"}, 64'(bus.in_ready), 64'd1);
        bus.a = a; bus.b = b; bus.c_in = ci; bus.in_valid = 1'b1; bus.out_ready = 1'b0;
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk({tag, "_busy"}, 64'(busy), 64'd1);
        chk({tag, "_nrdy"}, 64'(bus.in_ready), 64'd0);
        n = 0;
        while (!bus.out_valid && n < 4*W) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_lat"}, 64'(n), 64'(W));
        chk({tag, "_res"}, 64'({bus.c_out, bus.sum}), exp);
`ifdef SERIAL_ADDER_OVF_EN
        chk({tag, "_ovf"}, 64'(bus.ovf), 64'(ref_ovf(a, b, ci)));
`endif
        // Backpressure with a competing operand offered; it must be ignored.
        for (int i = 0; i < hold; i++) begin
            bus.in_valid = 1'b1; bus.a = ~a; bus.b = ~b;
            @(negedge clk);
            chk({tag, "_hold_v"}, 64'(bus.out_valid), 64'd1);
            chk({tag, "_hold_r"}, 64'({bus.c_out, bus.sum}), exp);
            chk({tag, "_hold_nrdy"}, 64'(bus.in_ready), 64'd0);
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk({tag, "_drop_v"}, 64'(bus.out_valid), 64'd0);
        chk({tag, "_idle_rdy"}, 64'(bus.in_ready), 64'd1);
        chk({tag, "_idle_busy"}, 64'(busy), 64'd0);
    endtask

    logic [W-1:0] qa[$];
    logic [W-1:0] qb[$];
    logic         qc[$];

    initial begin
        int n;
        bit seen_v;
        int sent, got, cyc;
        bit acc;
        logic [W-1:0] ea, eb;
        logic ec;

        rst = 1'b1;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.a = '0; bus.b = '0; bus.c_in = 1'b0;
        #12;
        chk("rst_rdy",  64'(bus.in_ready), 64'd1);
        chk("rst_ov",   64'(bus.out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_sum",  64'(bus.sum), 64'd0);
        chk("rst_cout", 64'(bus.c_out), 64'd0);
`ifdef SERIAL_ADDER_OVF_EN
        chk("rst_ovf",  64'(bus.ovf), 64'd0);
`endif
        @(negedge clk);
        rst = 1'b0;

        run_op("ff_01",  8'hFF, 8'h01, 1'b0, 0);
        run_op("00_00c", 8'h00, 8'h00, 1'b1, 0);
        run_op("ff_ffc", 8'hFF, 8'hFF, 1'b1, 0);
        run_op("7f_01",  8'h7F, 8'h01, 1'b0, 0);
        run_op("80_80",  8'h80, 8'h80, 1'b0, 0);
        run_op("bp",     8'h3C, 8'hA5, 1'b1, 5);

        // Reset while three bits are done (counter at 3).
        @(negedge clk);
        bus.a = 8'h5A; bus.b = 8'h6B; bus.c_in = 1'b1; bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_rdy",  64'(bus.in_ready), 64'd1);
        chk("mid_rst_ov",   64'(bus.out_valid), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_res",  64'({bus.c_out, bus.sum}), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        seen_v = 1'b0;
        n = 0;
        repeat (W + 3) begin
            @(negedge clk);
            if (bus.out_valid) seen_v = 1'b1;
            if (!bus.in_ready) n++;
        end
        chk("mid_rst_nopulse", 64'(seen_v), 64'd0);
        chk("mid_rst_stay_rdy", 64'(n), 64'd0);
        run_op("after_rst", 8'hC3, 8'h4E, 1'b0, 0);

        // Random traffic with independent producer/consumer gaps.
        sent = 0; got = 0; cyc = 0; acc = 1'b0;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        while (got < 200 && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            if (acc) begin
                bus.in_valid = 1'b0;
                acc = 1'b0;
            end
            if (bus.out_valid && $urandom_range(0, 2) != 0) begin
                bus.out_ready = 1'b1;
                if (qa.size() == 0) begin
                    chk("rnd_sb_empty", 64'd0, 64'd1);
                end else begin
                    ea = qa.pop_front(); eb = qb.pop_front(); ec = qc.pop_front();
                    chk("rnd_res", 64'({bus.c_out, bus.sum}), ref_add(ea, eb, ec));
`ifdef SERIAL_ADDER_OVF_EN
                    chk("rnd_ovf", 64'(bus.ovf), 64'(ref_ovf(ea, eb, ec)));
`endif
                end
                got++;
            end else if (bus.out_valid) begin
                bus.out_ready = 1'b0;
            end else begin
                bus.out_ready = 1'($urandom_range(0, 1));
            end
            if (!bus.in_valid && sent < 200 && $urandom_range(0, 3) != 0) begin
                bus.a = W'($urandom);
                bus.b = W'($urandom);
                bus.c_in = 1'($urandom_range(0, 1));
                bus.in_valid = 1'b1;
            end
            if (bus.in_valid && bus.in_ready) begin
                qa.push_back(bus.a); qb.push_back(bus.b); qc.push_back(bus.c_in);
                sent++;
                acc = 1'b1;
            end
        end
        chk("rnd_count", 64'(got), 64'd200);
        chk("rnd_left", 64'(qa.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
